// File: rtl/xy_input_unit_pkg.sv
// Shared definitions for the mesh input stage: flit type codes, router port IDs,
// flit field offsets and the input-unit FSM states.
package xy_input_unit_pkg;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_TAIL      = 2'b01,
    FT_HEAD      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  // Output channel IDs, shared with the XY router.
  localparam logic [2:0] PORT_RESOURCE = 3'd0;
  localparam logic [2:0] PORT_LEFT     = 3'd1;
  localparam logic [2:0] PORT_UP       = 3'd2;
  localparam logic [2:0] PORT_RIGHT    = 3'd3;
  localparam logic [2:0] PORT_DOWN     = 3'd4;

  // Head flit field offsets: column in the low bits, row directly above it.
  localparam int COL_LSB = 0;
  function automatic int row_lsb(input int col_w);
    return COL_LSB + col_w;
  endfunction

  function automatic int type_msb(input int id_w, input int data_w);
    return id_w + data_w - 1;
  endfunction

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

endpackage

// File: rtl/xy_input_unit_fifo.sv
// Synchronous flit FIFO, depth 2**DEPTH_W, no fall-through; full/empty from
// a registered occupancy count.
module xy_input_unit_fifo #(
  parameter int WIDTH   = 10,
  parameter int DEPTH_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_W;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_W:0]   count;
  logic               do_push, do_pop;

  assign full    = (count == (DEPTH_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // Full is checked against registered state, so a pop cannot make room in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xy_input_unit.sv
// Mesh switch input unit: buffers flits, exposes the head destination to the
// XY router, holds the chosen route for the whole packet and streams it out.
module xy_input_unit
  import xy_input_unit_pkg::*;
#(
  parameter int FLIT_DATA_W    = 8,
  parameter int FLIT_ID_W      = 2,
  parameter int COL_ADDR_W     = 4,
  parameter int ROW_ADDR_W     = 4,
  parameter int OUT_N_W        = 3,
  parameter int BUFFER_DEPTH_W = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [FLIT_ID_W+FLIT_DATA_W-1:0] data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [COL_ADDR_W-1:0]         col_addr_o,
  output logic [ROW_ADDR_W-1:0]         row_addr_o,
  input  logic [OUT_N_W-1:0]            out_chan_sel_i,
  output logic [FLIT_ID_W+FLIT_DATA_W-1:0] data_o,
  output logic                          valid_o,
  output logic [OUT_N_W-1:0]            out_chan_sel_o,
  input  logic                          ready_i,
  output logic                          err_o
);
  localparam int FLIT_W = FLIT_ID_W + FLIT_DATA_W;

  logic [FLIT_W-1:0]    front;
  logic [FLIT_ID_W-1:0] ftype;
  logic                 full, empty, pop;
  logic                 is_head, is_tail;
  state_e               state, state_nx;
  logic                 latch, err_nx, first, first_nx;

  xy_input_unit_fifo #(
    .WIDTH   (FLIT_W),
    .DEPTH_W (BUFFER_DEPTH_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (valid_i),
    .pop   (pop),
    .din   (data_i),
    .dout  (front),
    .full  (full),
    .empty (empty)
  );

  assign ready_o    = !full;
  assign data_o     = front;
  assign ftype      = front[type_msb(FLIT_ID_W, FLIT_DATA_W) -: FLIT_ID_W];
  assign col_addr_o = front[COL_LSB +: COL_ADDR_W];
  assign row_addr_o = front[row_lsb(COL_ADDR_W) +: ROW_ADDR_W];
  assign is_head    = (ftype == FLIT_ID_W'(FT_HEAD)) || (ftype == FLIT_ID_W'(FT_HEAD_TAIL));
  assign is_tail    = (ftype == FLIT_ID_W'(FT_TAIL)) || (ftype == FLIT_ID_W'(FT_HEAD_TAIL));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      out_chan_sel_o <= '0;
      err_o          <= 1'b0;
      first          <= 1'b0;
    end else begin
      state <= state_nx;
      err_o <= err_nx;
      first <= first_nx;
      if (latch) out_chan_sel_o <= out_chan_sel_i;
    end
  end

  always_comb begin
    state_nx = state;
    first_nx = first;
    pop      = 1'b0;
    latch    = 1'b0;
    err_nx   = 1'b0;
    valid_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          if (is_head) begin
            latch    = 1'b1;
            first_nx = 1'b1;
            state_nx = S_ACTIVE;
          end else begin
            // Orphan body/tail: drop it so the port cannot wedge.
            pop    = 1'b1;
            err_nx = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        valid_o = !empty;
        if (!empty && ready_i) begin
          pop      = 1'b1;
          first_nx = 1'b0;
          // A head inside a packet is forwarded as data but flagged.
          if (is_head && !first) err_nx = 1'b1;
          if (is_tail) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xy_input_unit.sv
// Bench for xy_input_unit with a behavioural XY router at (1,1) and a flit scoreboard.
module tb_xy_input_unit;
  localparam int FW = 10;
  localparam int MY_COL = 1;
  localparam int MY_ROW = 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [FW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [3:0]    col_addr_o, row_addr_o;
  logic [2:0]    out_chan_sel_i;
  logic [FW-1:0] data_o;
  logic          valid_o;
  logic [2:0]    out_chan_sel_o;
  logic          ready_i = 1'b1;
  logic          err_o;

  always #5 clk = ~clk;

  xy_input_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .col_addr_o     (col_addr_o),
    .row_addr_o     (row_addr_o),
    .out_chan_sel_i (out_chan_sel_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .out_chan_sel_o (out_chan_sel_o),
    .ready_i        (ready_i),
    .err_o          (err_o)
  );

  // XY router beside the unit: resolve column first, then row.
  always_comb begin
    if (int'(col_addr_o) < MY_COL)      out_chan_sel_i = 3'd1;
    else if (int'(col_addr_o) > MY_COL) out_chan_sel_i = 3'd3;
    else if (int'(row_addr_o) < MY_ROW) out_chan_sel_i = 3'd2;
    else if (int'(row_addr_o) > MY_ROW) out_chan_sel_i = 3'd4;
    else                                out_chan_sel_i = 3'd0;
  end

  typedef struct {
    logic [FW-1:0] flit;
    logic [2:0]    chan;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, pops = 0, errs = 0, rise_cyc = -1, last_wr = 0;
  int   pop_cyc[$];
  logic prev_v = 1'b0;
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int col, input int row);
    return {t, 4'(row), 4'(col)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o && !prev_v) rise_cyc = cyc;
      if (err_o) errs++;
      if (valid_o && ready_i) begin
        if (sb.size() == 0) chk("unexpected_out", 32'(data_o), 32'hFFFF);
        else begin
          mon_e = sb.pop_front();
          chk("out_data", 32'(data_o), 32'(mon_e.flit));
          chk("out_chan", 32'(out_chan_sel_o), 32'(mon_e.chan));
        end
        pops++;
        pop_cyc.push_back(cyc);
      end
    end
    prev_v = valid_o;
  end

  task automatic send(input logic [FW-1:0] f, input logic [2:0] ch, input bit exp_out);
    bit r = 1'b0;
    int t = 0;
    data_i  = f;
    valid_i = 1'b1;
    forever begin
      @(negedge clk);
      r = ready_o;
      @(posedge clk);
      #1;
      if (r) break;
      if (++t > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    valid_i = 1'b0;
    if (r) begin
      last_wr = cyc;
      if (exp_out) sb.push_back('{f, ch});
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0) begin
      @(posedge clk);
      #1;
      if (++t > 100) begin
        chk(tag, 32'(sb.size()), 0);
        sb.delete();
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int hc, p0;
    step(3);
    rst_i = 1'b0;
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_chan", 32'(out_chan_sel_o), 0);

    // Packet to (3,1): routed right, 4 flits back to back.
    pop_cyc.delete();
    p0 = pops;
    send(mk(2'b10, 3, 1), 3'd3, 1);
    hc = last_wr;
    send({2'b00, 8'h11}, 3'd3, 1);
    send({2'b00, 8'h22}, 3'd3, 1);
    send({2'b01, 8'h33}, 3'd3, 1);
    drain("t1_drain");
    chk("t1_latency", 32'(rise_cyc - hc), 1);
    chk("t1_count", 32'(pops - p0), 4);
    if (pop_cyc.size() >= 4) chk("t1_burst", 32'(pop_cyc[3] - pop_cyc[0]), 3);
    chk("t1_chan_hold", 32'(out_chan_sel_o), 3);
    chk("t1_idle", 32'(valid_o), 0);

    // Single-flit packet to the local resource.
    p0 = pops;
    send(mk(2'b11, 1, 1), 3'd0, 1);
    drain("t2_drain");
    chk("t2_count", 32'(pops - p0), 1);
    chk("t2_chan", 32'(out_chan_sel_o), 0);
    chk("t2_idle", 32'(valid_o), 0);

    // Backpressure: fill the FIFO, fifth flit must wait upstream.
    ready_i = 1'b0;
    p0 = pops;
    send(mk(2'b10, 1, 0), 3'd2, 1);
    send({2'b00, 8'h44}, 3'd2, 1);
    send({2'b00, 8'h55}, 3'd2, 1);
    send({2'b00, 8'h66}, 3'd2, 1);
    chk("t3_full", 32'(ready_o), 0);
    fork
      send({2'b01, 8'h77}, 3'd2, 1);
    join_none
    step(3);
    chk("t3_still_full", 32'(ready_o), 0);
    chk("t3_valid_held", 32'(valid_o), 1);
    chk("t3_front", 32'(data_o), 32'(mk(2'b10, 1, 0)));
    chk("t3_chan", 32'(out_chan_sel_o), 2);
    ready_i = 1'b1;
    wait fork;
    drain("t3_drain");
    chk("t3_count", 32'(pops - p0), 5);

    // Orphan body in IDLE: dropped, one-cycle error pulse, nothing output.
    p0 = pops;
    send({2'b00, 8'h99}, 3'd0, 0);
    @(negedge clk);
    chk("t4_err_early", 32'(err_o), 0);
    @(negedge clk);
    chk("t4_err_pulse", 32'(err_o), 1);
    chk("t4_no_valid", 32'(valid_o), 0);
    @(negedge clk);
    chk("t4_err_clear", 32'(err_o), 0);
    step(1);
    chk("t4_no_out", 32'(pops - p0), 0);
    chk("t4_ready", 32'(ready_o), 1);

    // Back-to-back packets: left then down, one bubble between them.
    pop_cyc.delete();
    send(mk(2'b10, 0, 1), 3'd1, 1);
    send({2'b01, 8'hA1}, 3'd1, 1);
    send(mk(2'b10, 1, 3), 3'd4, 1);
    send({2'b01, 8'hB1}, 3'd4, 1);
    drain("t5_drain");
    chk("t5_count", 32'(pop_cyc.size()), 4);
    if (pop_cyc.size() >= 4) begin
      chk("t5_pkt1", 32'(pop_cyc[1] - pop_cyc[0]), 1);
      chk("t5_bubble", 32'(pop_cyc[2] - pop_cyc[1]), 2);
      chk("t5_pkt2", 32'(pop_cyc[3] - pop_cyc[2]), 1);
    end

    // Reset mid-packet after two flits have left.
    p0 = pops;
    send(mk(2'b10, 3, 2), 3'd3, 1);
    send({2'b00, 8'hC1}, 3'd3, 1);
    send({2'b00, 8'hC2}, 3'd3, 1);
    send({2'b01, 8'hC3}, 3'd3, 1);
    begin
      int t = 0;
      while (pops - p0 < 2 && t < 50) begin
        step(1);
        t++;
      end
    end
    chk("t6_two_out", 32'(pops - p0), 2);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    sb.delete();
    chk("t6_ready", 32'(ready_o), 1);
    chk("t6_valid", 32'(valid_o), 0);
    chk("t6_chan", 32'(out_chan_sel_o), 0);
    chk("t6_err", 32'(err_o), 0);
    step(2);
    chk("t6_empty", 32'(valid_o), 0);
    p0 = pops;
    send(mk(2'b10, 0, 0), 3'd1, 1);
    send({2'b01, 8'hD1}, 3'd1, 1);
    drain("t6_drain");
    chk("t6_count", 32'(pops - p0), 2);
    chk("t6_route", 32'(out_chan_sel_o), 1);

    chk("err_total", 32'(errs), 1);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
